// File: rtl/afe_spi_if.sv
// SPI lane between spi_master and one AFE responder: chip select, mode-0 clock, data pair.
interface afe_spi_if;
    logic CS_b;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (
        output CS_b,
        output SCLK,
        output MOSI,
        input  MISO
    );

    modport slave (
        input  CS_b,
        input  SCLK,
        input  MOSI,
        output MISO
    );
endinterface

// File: rtl/afe_spi_responder.sv
// SPI mode-0 slave modelling one AFE amplifier chip: 16-bit commands, replies two frames late.
// Optional feature macro AFE_RESP_RAMP_EN: per-channel 16-bit ramps supply CONVERT samples.
module afe_spi_responder #(
    parameter int unsigned NUM_CH      = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RAMP_STEP   = 1
) (
    input  logic        CLK,
    input  logic        RST_b,
    afe_spi_if.slave    spi,
    output logic        frame_done,
    output logic        frame_err,
    output logic [15:0] cmd_last
);
    typedef enum logic [1:0] {StWaitIdle, StIdle, StShift, StEnd} state_e;

    localparam logic [6:0] ChLimit = 7'(NUM_CH);

    state_e r_state;
    state_e w_state_next;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_cs_prev;
    logic                   r_sclk_prev;
    logic                   w_cs;
    logic                   w_sclk;
    logic                   w_mosi;
    logic                   w_cs_fall;
    logic                   w_cs_rise;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;

    logic [15:0] r_rx;
    logic [15:0] r_tx_shift;
    logic [15:0] r_tx_next;
    logic [15:0] r_pipe;
    logic [15:0] r_cmd_last;
    logic [4:0]  r_bit_cnt;
    logic [7:0]  r_regs [8];

    logic [5:0]  w_addr;
    logic [7:0]  w_data;
    logic        w_in_range;
    logic        w_frame_ok;
    logic [15:0] w_sample;
    logic [15:0] w_reply;
    logic [7:0]  w_rd_val;

    // Synchronizers reset to 0 so a CS_b high must genuinely propagate before a frame can start.
    always_ff @(posedge CLK or negedge RST_b) begin
        if (!RST_b) begin
            r_cs_sync   <= '0;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_prev   <= 1'b0;
            r_sclk_prev <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi.CS_b};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
            r_cs_prev   <= w_cs;
            r_sclk_prev <= w_sclk;
        end
    end

    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_fall   = r_cs_prev & ~w_cs;
    assign w_cs_rise   = ~r_cs_prev & w_cs;
    assign w_sclk_rise = ~r_sclk_prev & w_sclk;
    assign w_sclk_fall = r_sclk_prev & ~w_sclk;

    assign w_addr     = r_rx[13:8];
    assign w_data     = r_rx[7:0];
    assign w_frame_ok = (r_bit_cnt == 5'd16);

    always_ff @(posedge CLK or negedge RST_b) begin
        if (!RST_b) begin
            r_state <= StWaitIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StWaitIdle: if (w_cs)      w_state_next = StIdle;
            StIdle:     if (w_cs_fall) w_state_next = StShift;
            StShift:    if (w_cs_rise) w_state_next = StEnd;
            StEnd:                     w_state_next = StIdle;
            default:                   w_state_next = StWaitIdle;
        endcase
    end

    always_comb begin
        frame_done = 1'b0;
        frame_err  = 1'b0;
        spi.MISO   = 1'b0;
        unique case (r_state)
            StShift: spi.MISO = r_tx_shift[15];
            StEnd: begin
                frame_done = w_frame_ok;
                frame_err  = ~w_frame_ok;
            end
            default: ;
        endcase
    end

    assign cmd_last = r_cmd_last;

`ifdef AFE_RESP_RAMP_EN
    logic [15:0] r_ramp [NUM_CH];

    always_ff @(posedge CLK or negedge RST_b) begin
        if (!RST_b) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_ramp[i] <= '0;
            end
        end else if (r_state == StEnd && w_frame_ok) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (r_rx[15:14] == 2'b01) begin
                    r_ramp[i] <= '0;
                end else if (r_rx[15:14] == 2'b00 && w_addr == 6'(i)) begin
                    r_ramp[i] <= r_ramp[i] + 16'(RAMP_STEP);
                end
            end
        end
    end

    always_comb begin
        w_sample = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_addr == 6'(i)) w_sample = r_ramp[i];
        end
    end
`else
    logic w_unused_ramp_step;
    assign w_unused_ramp_step = ^RAMP_STEP;
    assign w_sample           = {2'b10, w_addr, 8'h00};
`endif

    always_comb begin
        w_in_range = ({1'b0, w_addr} < ChLimit);
        w_rd_val   = 8'h00;
        if (w_addr[5:3] == 3'b000) begin
            w_rd_val = r_regs[w_addr[2:0]];
        end else begin
            unique case (w_addr)
                6'd40:   w_rd_val = 8'h49;
                6'd41:   w_rd_val = 8'h4E;
                6'd42:   w_rd_val = 8'h54;
                6'd43:   w_rd_val = 8'h41;
                6'd44:   w_rd_val = 8'h4E;
                default: w_rd_val = 8'h00;
            endcase
        end
        unique case (r_rx[15:14])
            2'b00:   w_reply = w_in_range ? w_sample : 16'h0000;
            2'b01:   w_reply = 16'h0000;
            2'b10:   w_reply = {8'hFF, w_data};
            default: w_reply = {8'h00, w_rd_val};
        endcase
    end

    always_ff @(posedge CLK or negedge RST_b) begin
        if (!RST_b) begin
            r_rx       <= '0;
            r_tx_shift <= '0;
            r_tx_next  <= '0;
            r_pipe     <= '0;
            r_cmd_last <= '0;
            r_bit_cnt  <= '0;
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_cs_fall) begin
                        r_tx_shift <= r_tx_next;
                        r_bit_cnt  <= '0;
                    end
                end
                StShift: begin
                    // A CS_b rise in the same cycle closes the frame and masks any SCLK edge.
                    if (!w_cs_rise) begin
                        if (w_sclk_rise) begin
                            r_rx      <= {r_rx[14:0], w_mosi};
                            r_bit_cnt <= (r_bit_cnt == 5'd31) ? r_bit_cnt : r_bit_cnt + 5'd1;
                        end
                        if (w_sclk_fall) begin
                            r_tx_shift <= {r_tx_shift[14:0], 1'b0};
                        end
                    end
                end
                StEnd: begin
                    if (w_frame_ok) begin
                        r_cmd_last <= r_rx;
                        r_tx_next  <= r_pipe;
                        r_pipe     <= w_reply;
                        if (r_rx[15:14] == 2'b10 && w_addr[5:3] == 3'b000) begin
                            r_regs[w_addr[2:0]] <= w_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
